// File: rtl/ftdi_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_fifo_arbiter
// Description : Arbiter for an FT245-style synchronous FIFO interface. One
//               shared 8-bit bus is time-multiplexed between reading bytes
//               from the FTDI (into a 4-entry RX FIFO) and writing bytes to
//               the FTDI (from a 1-byte TX holding register). Each grant
//               moves at most MAX_BURST bytes. When both directions are
//               waiting, grants alternate between them (round-robin).
//
// Parameters
//   MAX_BURST     bytes moved per grant before re-arbitration (1..255)
//
// Ports
//   clk           60 MHz FIFO clock, all logic on the rising edge
//   reset_n       asynchronous active-low reset
//   ftdi_rxf_n    low = FTDI holds receive data
//   ftdi_txe_n    low = FTDI can accept transmit data
//   ftdi_data_i   FTDI data bus, input half
//   ftdi_data_o   FTDI data bus, output half (TX holding register)
//   ftdi_data_oe  high = FPGA drives the data bus
//   ftdi_rd_n     FTDI read strobe, active low
//   ftdi_wr_n     FTDI write strobe, active low
//   ftdi_oe_n     FTDI output enable, active low
//   tx_valid/tx_data/tx_ready   host-bound byte stream (valid/ready)
//   rx_valid/rx_data/rx_ready   FPGA-bound byte stream (valid/ready)
//   state_dbg     current FSM state: 0 IDLE, 1 RX_OE, 2 RX_READ,
//                 3 RX_TURN, 4 TX_WRITE
//
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_fifo_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ftdi_rxf_n,
  input  logic       ftdi_txe_n,
  input  logic [7:0] ftdi_data_i,
  output logic [7:0] ftdi_data_o,
  output logic       ftdi_data_oe,
  output logic       ftdi_rd_n,
  output logic       ftdi_wr_n,
  output logic       ftdi_oe_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [2:0] state_dbg
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_OE    = 3'd1,
    ST_RX_READ  = 3'd2,
    ST_RX_TURN  = 3'd3,
    ST_TX_WRITE = 3'd4
  } state_t;

  localparam logic [7:0] c_max_burst  = 8'(MAX_BURST);
  localparam logic [2:0] c_fifo_depth = 3'd4;
  localparam logic       c_grant_rx   = 1'b0;
  localparam logic       c_grant_tx   = 1'b1;

  // --------------------------------------------------------------------------
  // Registers and next-state values
  // --------------------------------------------------------------------------
  state_t      state_q,      state_d;
  logic [7:0]  burst_cnt_q,  burst_cnt_d;
  logic        last_grant_q, last_grant_d;

  logic        hold_valid_q, hold_valid_d;
  logic [7:0]  hold_data_q,  hold_data_d;

  logic [7:0]  fifo_mem_q [4];
  logic [1:0]  wr_ptr_q,     wr_ptr_d;
  logic [1:0]  rd_ptr_q,     rd_ptr_d;
  logic [2:0]  count_q,      count_d;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic       in_tx_write;
  logic       in_rx_read;
  logic       fifo_full;
  logic       fifo_empty;
  logic       tx_xfer;
  logic       tx_load;
  logic       rx_xfer;
  logic       rx_pop;
  logic       rx_req;
  logic       tx_req;
  logic [7:0] burst_next;
  logic       burst_hit;

  assign in_tx_write = (state_q == ST_TX_WRITE);
  assign in_rx_read  = (state_q == ST_RX_READ);
  assign fifo_full   = (count_q == c_fifo_depth);
  assign fifo_empty  = (count_q == 3'd0);

  // TX side: the holding register can accept a new byte in the same cycle
  // it hands its current byte to the FTDI, which keeps bursts gap-free.
  assign tx_xfer  = in_tx_write & hold_valid_q & ~ftdi_txe_n;
  assign tx_ready = ~hold_valid_q | tx_xfer;
  assign tx_load  = tx_valid & tx_ready;

  assign ftdi_wr_n    = ~(in_tx_write & hold_valid_q);
  assign ftdi_data_o  = hold_data_q;
  assign ftdi_data_oe = in_tx_write;

  // RX side: RD is withheld when the FIFO is full so no byte is ever pulled
  // off the FTDI without somewhere to put it.
  assign ftdi_oe_n = ~((state_q == ST_RX_OE) | in_rx_read);
  assign ftdi_rd_n = ~(in_rx_read & ~fifo_full);
  assign rx_xfer   = ~ftdi_rd_n & ~ftdi_rxf_n;

  assign rx_valid = ~fifo_empty;
  assign rx_data  = fifo_mem_q[rd_ptr_q];
  assign rx_pop   = rx_valid & rx_ready;

  assign rx_req = ~ftdi_rxf_n & ~fifo_full;
  assign tx_req = hold_valid_q & ~ftdi_txe_n;

  assign state_dbg = state_q;

  // Saturating increment so the counter can never wrap inside a grant.
  assign burst_next = (burst_cnt_q == 8'hFF) ? 8'hFF : (burst_cnt_q + 8'd1);
  assign burst_hit  = (burst_next == c_max_burst);

  // --------------------------------------------------------------------------
  // TX holding register next state
  // --------------------------------------------------------------------------
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (tx_load) begin
      hold_valid_d = 1'b1;
      hold_data_d  = tx_data;
    end else if (tx_xfer) begin
      hold_valid_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rx_xfer) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (rx_pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({rx_xfer, rx_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Arbitration / bus-phase FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        // RX wins when it is the only requester or when TX had the last turn.
        if (rx_req && (!tx_req || (last_grant_q == c_grant_tx))) begin
          state_d      = ST_RX_OE;
          burst_cnt_d  = 8'd0;
          last_grant_d = c_grant_rx;
        end else if (tx_req) begin
          state_d      = ST_TX_WRITE;
          burst_cnt_d  = 8'd0;
          last_grant_d = c_grant_tx;
        end
      end
      // One cycle with OE low and RD high lets the FTDI take the bus before
      // the first read strobe.
      ST_RX_OE: begin
        state_d = ST_RX_READ;
      end
      ST_RX_READ: begin
        if (rx_xfer) begin
          burst_cnt_d = burst_next;
        end
        if (ftdi_rxf_n || (count_d == c_fifo_depth) || (rx_xfer && burst_hit)) begin
          state_d = ST_RX_TURN;
        end
      end
      // One cycle with OE released and the bus undriven before anyone else
      // may use it.
      ST_RX_TURN: begin
        state_d = ST_IDLE;
      end
      ST_TX_WRITE: begin
        if (tx_xfer) begin
          burst_cnt_d = burst_next;
        end
        if (ftdi_txe_n || !hold_valid_d || (tx_xfer && burst_hit)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      burst_cnt_q  <= 8'd0;
      last_grant_q <= c_grant_tx;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'd0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      count_q      <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= 8'd0;
      end
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_grant_q <= last_grant_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      if (rx_xfer) begin
        fifo_mem_q[wr_ptr_q] <= ftdi_data_i;
      end
    end
  end

endmodule
`default_nettype wire
